bdf_sched_loader: RTL

- Host-facing schedule loader that sits directly upstream of the bdf controller port group: load_ctrl, ctrl_in, start_ctrl, stop_ctrl.
- Accepts the iteration schedule as a byte stream over a valid/ready handshake, assembles CTRL_WIDTH-bit control words, and issues one load_ctrl pulse per word.
- Checks that exactly ITER_PERIOD words were delivered, then converts host start/stop commands into single-cycle start_ctrl/stop_ctrl pulses.
- Runs in the controller's clock domain (clk2 at top level).

---
 rtl/bdf_sched_loader_pkg.sv | 19 +
 rtl/bdf_sched_loader_packer.sv | 59 +++++
 rtl/bdf_sched_loader.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/bdf_sched_loader_pkg.sv
// Shared types and helpers for the bdf schedule loader.
package bdf_sched_loader_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StReady,
    StRun,
    StErr
  } loader_state_e;

  // Number of host bytes needed to carry one control word.
  function automatic int unsigned ctrl_bytes(input int unsigned width);
    return (width + BYTE_W - 1) / BYTE_W;
  endfunction

endpackage

// File: rtl/bdf_sched_loader_packer.sv
// Assembles LSB-first host bytes into one control word.
// word_done/word are combinational so the caller can register them
// in the same cycle as the final byte transfer.
module bdf_sched_loader_packer
  import bdf_sched_loader_pkg::*;
#(
  parameter int unsigned CTRL_WIDTH     = 24,
  parameter int unsigned BYTES_PER_WORD = ctrl_bytes(CTRL_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic [BYTE_W-1:0]     byte_data,
  output logic                  word_done,
  output logic [CTRL_WIDTH-1:0] word
);

  localparam int unsigned AsmW = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned CntW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(BYTES_PER_WORD - 1);

  logic [CntW-1:0] cnt_q;
  logic [AsmW-1:0] asm_q;
  logic [AsmW-1:0] asm_ins;

  // Insert the incoming byte at the lane selected by the byte counter.
  always_comb begin
    asm_ins = asm_q;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (cnt_q == CntW'(k)) begin
        asm_ins[k*BYTE_W +: BYTE_W] = byte_data;
      end
    end
  end

  assign word_done = byte_valid && (cnt_q == LastIdx);
  assign word      = asm_ins[CTRL_WIDTH-1:0];

  // Byte counter and partial-word register; clear has priority over a byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else if (byte_valid) begin
      if (word_done) begin
        cnt_q <= '0;
        asm_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
        asm_q <= asm_ins;
      end
    end
  end

endmodule

// File: rtl/bdf_sched_loader.sv
// Host-facing schedule loader for the bdf controller: packs host bytes into
// control words, checks schedule framing, and turns start/stop commands
// into single-cycle controller pulses. All outputs are registered.
module bdf_sched_loader
  import bdf_sched_loader_pkg::*;
#(
  parameter int unsigned NUM_BUFFS      = 12,
  parameter int unsigned CTRL_WIDTH     = NUM_BUFFS * 2,
  parameter int unsigned ITER_PERIOD    = 48,
  parameter int unsigned BYTES_PER_WORD = ctrl_bytes(CTRL_WIDTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             host_valid,
  output logic                             host_ready,
  input  logic [BYTE_W-1:0]                host_byte,
  input  logic                             host_last,
  input  logic                             cmd_start,
  input  logic                             cmd_stop,
  output logic                             load_ctrl,
  output logic [CTRL_WIDTH-1:0]            ctrl_in,
  output logic                             start_ctrl,
  output logic                             stop_ctrl,
  output logic                             running,
  output logic                             sched_err,
  output logic [$clog2(ITER_PERIOD+1)-1:0] words_loaded
);

  localparam int unsigned WcW = $clog2(ITER_PERIOD + 1);
  localparam logic [WcW-1:0] LastWord = WcW'(ITER_PERIOD - 1);

  loader_state_e state_q, state_d;
  logic [WcW-1:0]        words_q, words_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic                  load_q, load_d;
  logic                  start_q, start_d;
  logic                  stop_q, stop_d;
  logic                  run_q, run_d;
  logic                  err_q, err_d;
  logic                  ready_q, ready_d;

  logic                  xfer;
  logic                  pk_valid;
  logic                  pk_clear;
  logic                  pk_done;
  logic [CTRL_WIDTH-1:0] pk_word;

  // host_ready is only high in Idle/Load, so no extra state qualification.
  // A concurrent cmd_stop aborts and the byte is dropped.
  assign xfer     = host_valid && ready_q;
  assign pk_valid = xfer && !cmd_stop;

  bdf_sched_loader_packer #(
    .CTRL_WIDTH     (CTRL_WIDTH),
    .BYTES_PER_WORD (BYTES_PER_WORD)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pk_clear),
    .byte_valid (pk_valid),
    .byte_data  (host_byte),
    .word_done  (pk_done),
    .word       (pk_word)
  );

  // Next-state, word counting, framing checks and pulse generation.
  always_comb begin
    state_d  = state_q;
    words_d  = words_q;
    ctrl_d   = ctrl_q;
    load_d   = 1'b0;
    start_d  = 1'b0;
    stop_d   = 1'b0;
    run_d    = run_q;
    err_d    = err_q;
    pk_clear = 1'b0;

    unique case (state_q)
      StIdle, StLoad: begin
        if (cmd_stop) begin
          state_d  = StIdle;
          words_d  = '0;
          pk_clear = 1'b1;
        end else if (xfer) begin
          state_d = StLoad;
          if (pk_done && (words_q == LastWord)) begin
            // Final word is always loaded; missing host_last is flagged after.
            load_d  = 1'b1;
            ctrl_d  = pk_word;
            words_d = words_q + 1'b1;
            if (host_last) begin
              state_d = StReady;
            end else begin
              state_d = StErr;
              err_d   = 1'b1;
            end
          end else if (host_last) begin
            // Early end of schedule: drop the partial word.
            state_d  = StErr;
            err_d    = 1'b1;
            pk_clear = 1'b1;
          end else if (pk_done) begin
            load_d  = 1'b1;
            ctrl_d  = pk_word;
            words_d = words_q + 1'b1;
          end
        end
      end
      StReady: begin
        if (cmd_stop) begin
          state_d  = StIdle;
          words_d  = '0;
          pk_clear = 1'b1;
        end else if (cmd_start) begin
          state_d = StRun;
          start_d = 1'b1;
          run_d   = 1'b1;
        end
      end
      StRun: begin
        if (cmd_stop) begin
          state_d  = StIdle;
          stop_d   = 1'b1;
          run_d    = 1'b0;
          words_d  = '0;
          pk_clear = 1'b1;
        end
      end
      StErr: begin
        if (cmd_stop) begin
          state_d  = StIdle;
          err_d    = 1'b0;
          words_d  = '0;
          pk_clear = 1'b1;
        end
      end
      default: begin
        state_d  = StIdle;
        words_d  = '0;
        run_d    = 1'b0;
        pk_clear = 1'b1;
      end
    endcase

    ready_d = (state_d == StIdle) || (state_d == StLoad);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      words_q <= '0;
      ctrl_q  <= '0;
      load_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      run_q   <= run_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign host_ready   = ready_q;
  assign load_ctrl    = load_q;
  assign ctrl_in      = ctrl_q;
  assign start_ctrl   = start_q;
  assign stop_ctrl    = stop_q;
  assign running      = run_q;
  assign sched_err    = err_q;
  assign words_loaded = words_q;

endmodule
